// File: rtl/mem_port_arbiter_if.sv
// Requester and byte-memory bundle for mem_port_arbiter.
// master = requesters and memory array, slave = arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic              d_unsigned;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              d_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_size, d_unsigned,
    output d_addr, d_wdata,
    output mem_rdata,
    input  if_ack, if_rdata,
    input  d_ack, d_rdata, d_err,
    input  mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_size, d_unsigned,
    input  d_addr, d_wdata,
    input  mem_rdata,
    output if_ack, if_rdata,
    output d_ack, d_rdata, d_err,
    output mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter serialising words onto a byte memory.
// Define ARB_RR_EN for round-robin instead of data-first priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  mem_port_arbiter_if.slave bus,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN,
    ACK
  } state_t;

  state_t            state;
  logic [1:0]        cnt;
  logic [1:0]        last;
  logic              own_d;
  logic              we;
  logic              uns;
  logic [1:0]        size;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata;
  logic [31:0]       asm_q;
  logic              grant_d;
  logic [1:0]        nxt;
  logic [1:0]        prv;
  logic [31:0]       word;
  logic              unused_hi;

  assign unused_hi = ^{bus.if_addr[31:ADDR_W],
                       bus.d_addr[31:ADDR_W]};

`ifdef ARB_RR_EN
  logic last_d;

  // last_d = 1 when data won the most recent arbitration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (state == IDLE
                 && (bus.d_req || bus.if_req)) begin
      last_d <= grant_d;
    end
  end

  assign grant_d = bus.d_req
                 & (~bus.if_req | ~last_d);
`else
  assign grant_d = bus.d_req;
`endif

  always_comb begin
    nxt  = cnt + 2'd1;
    prv  = cnt - 2'd1;
    word = asm_q;
    word[{cnt, 3'b000} +: 8] = bus.mem_rdata;
  end

  function automatic logic [31:0] ext(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic        u
  );
    case (sz)
      2'b00:   ext = {{24{~u & w[7]}}, w[7:0]};
      2'b01:   ext = {{16{~u & w[15]}}, w[15:0]};
      default: ext = w;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 2'd0;
      last          <= 2'd0;
      own_d         <= 1'b0;
      we            <= 1'b0;
      uns           <= 1'b0;
      size          <= 2'b00;
      base          <= '0;
      wdata         <= '0;
      asm_q         <= '0;
      busy          <= 1'b0;
      bus.if_ack    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_ack     <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_err     <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_re    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
    end else begin
      bus.if_ack <= 1'b0;
      bus.d_ack  <= 1'b0;
      bus.d_err  <= 1'b0;
      bus.mem_re <= 1'b0;
      bus.mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            own_d <= 1'b1;
            we    <= bus.d_we;
            size  <= bus.d_size;
            uns   <= bus.d_unsigned;
            base  <= bus.d_addr[ADDR_W-1:0];
            wdata <= bus.d_wdata;
            cnt   <= 2'd0;
            asm_q <= '0;
            busy  <= 1'b1;
            if (bus.d_size == 2'b11) begin
              state     <= ACK;
              bus.d_ack <= 1'b1;
              bus.d_err <= 1'b1;
            end else begin
              state         <= XFER;
              last          <= {bus.d_size[1],
                                |bus.d_size};
              bus.mem_addr  <= bus.d_addr[ADDR_W-1:0];
              bus.mem_we    <= bus.d_we;
              bus.mem_re    <= ~bus.d_we;
              bus.mem_wdata <= bus.d_wdata[7:0];
            end
          end else if (bus.if_req) begin
            own_d        <= 1'b0;
            we           <= 1'b0;
            size         <= 2'b10;
            uns          <= 1'b0;
            base         <= bus.if_addr[ADDR_W-1:0];
            wdata        <= '0;
            cnt          <= 2'd0;
            last         <= 2'd3;
            asm_q        <= '0;
            busy         <= 1'b1;
            state        <= XFER;
            bus.mem_addr <= bus.if_addr[ADDR_W-1:0];
            bus.mem_re   <= 1'b1;
          end
        end
        XFER: begin
          // read data lags its strobe by one cycle
          if (!we && cnt != 2'd0) begin
            asm_q[{prv, 3'b000} +: 8] <= bus.mem_rdata;
          end
          if (cnt == last) begin
            if (we) begin
              state     <= ACK;
              bus.d_ack <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            cnt           <= nxt;
            bus.mem_addr  <= base + ADDR_W'(nxt);
            bus.mem_we    <= we;
            bus.mem_re    <= ~we;
            bus.mem_wdata <= wdata[{nxt, 3'b000} +: 8];
          end
        end
        DRAIN: begin
          state <= ACK;
          asm_q <= word;
          if (own_d) begin
            bus.d_ack   <= 1'b1;
            bus.d_rdata <= ext(word, size, uns);
          end else begin
            bus.if_ack   <= 1'b1;
            bus.if_rdata <= word;
          end
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte memory model.
// Sync-read memory, write/read logging, latency measured in edges.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  mem_port_arbiter_if #(.ADDR_W(8)) b();

  mem_port_arbiter #(.ADDR_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] re_a [16];
  logic [7:0] we_a [16];
  logic [7:0] we_d [16];
  int re_n = 0;
  int we_n = 0;
  int ov_n = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clk) begin
    if (b.mem_re && b.mem_we) ov_n++;
    if (b.mem_we) begin
      mem[b.mem_addr] = b.mem_wdata;
      if (we_n < 16) begin
        we_a[we_n] = b.mem_addr;
        we_d[we_n] = b.mem_wdata;
      end
      we_n++;
    end
    if (b.mem_re) begin
      b.mem_rdata <= mem[b.mem_addr];
      if (re_n < 16) re_a[re_n] = b.mem_addr;
      re_n++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input bit dat, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (dat ? b.d_ack : b.if_ack) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic idle_start();
    @(posedge clk);
    #1;
    re_n = 0;
    we_n = 0;
  endtask

  task automatic d_set(input bit w, input logic [1:0] sz,
                       input bit u, input logic [31:0] a,
                       input logic [31:0] wd);
    b.d_we       = w;
    b.d_size     = sz;
    b.d_unsigned = u;
    b.d_addr     = a;
    b.d_wdata    = wd;
  endtask

  function automatic logic [31:0] outs();
    return {10'd0, b.if_ack, b.d_ack, b.d_err,
            b.mem_re, b.mem_we, busy,
            b.mem_addr, b.mem_wdata};
  endfunction

  initial begin
    int cyc;
    int dc;
    int ic;
    logic [31:0] dv;
    logic [31:0] iv;
    logic [7:0] ea [4];

    b.if_req  = 1'b0;
    b.if_addr = '0;
    b.d_req   = 1'b0;
    d_set(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h78;
    mem[8'h11] = 8'h56;
    mem[8'h12] = 8'h34;
    mem[8'h13] = 8'h12;
    mem[8'h20] = 8'h80;
    mem[8'h22] = 8'h01;
    mem[8'h23] = 8'h90;
    mem[8'h30] = 8'hEF;
    mem[8'h31] = 8'hBE;
    mem[8'h32] = 8'hAD;
    mem[8'h33] = 8'hDE;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", outs(), 32'h0);
    chk("rst_if_rdata", b.if_rdata, 32'h0);
    chk("rst_d_rdata", b.d_rdata, 32'h0);
    rst_n = 1'b1;

    // fetch word at 0x10
    idle_start();
    b.if_addr = 32'h10;
    b.if_req  = 1'b1;
    wait_ack(1'b0, cyc);
    b.if_req = 1'b0;
    chk("fetch_lat", cyc, 6);
    chk("fetch_data", b.if_rdata, 32'h12345678);
    chk("fetch_re_n", re_n, 4);
    chk("fetch_we_n", we_n, 0);
    for (int k = 0; k < 4; k++)
      chk("fetch_re_addr", re_a[k], 32'h10 + k);

    // simultaneous: lw 0x10 and fetch 0x30
    idle_start();
    d_set(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    b.if_addr = 32'h30;
    b.d_req   = 1'b1;
    b.if_req  = 1'b1;
    dc = -1;
    ic = -1;
    dv = '0;
    iv = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (b.d_ack) begin
        dc = i;
        dv = b.d_rdata;
        b.d_req = 1'b0;
      end
      if (b.if_ack) begin
        ic = i;
        iv = b.if_rdata;
        b.if_req = 1'b0;
        break;
      end
    end
    b.d_req  = 1'b0;
    b.if_req = 1'b0;
    chk("both_d_lat", dc, 6);
    chk("both_if_lat", ic, 13);
    chk("both_d_data", dv, 32'h12345678);
    chk("both_if_data", iv, 32'hDEADBEEF);
    chk("both_d_hold", b.d_rdata, 32'h12345678);
    chk("both_re_n", re_n, 8);

    // halfword store wrapping 0xFF -> 0x00
    idle_start();
    d_set(1'b1, 2'b01, 1'b0, 32'hFF, 32'hAABBCCDD);
    b.d_req = 1'b1;
    wait_ack(1'b1, cyc);
    b.d_req = 1'b0;
    chk("sh_lat", cyc, 3);
    chk("sh_err", b.d_err, 32'h0);
    chk("sh_we_n", we_n, 2);
    chk("sh_re_n", re_n, 0);
    chk("sh_a0", we_a[0], 32'hFF);
    chk("sh_d0", we_d[0], 32'hDD);
    chk("sh_a1", we_a[1], 32'h00);
    chk("sh_d1", we_d[1], 32'hCC);

    // lb / lbu of 0x80
    idle_start();
    d_set(1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
    b.d_req = 1'b1;
    wait_ack(1'b1, cyc);
    b.d_req = 1'b0;
    chk("lb_lat", cyc, 3);
    chk("lb_data", b.d_rdata, 32'hFFFFFF80);

    idle_start();
    d_set(1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
    b.d_req = 1'b1;
    wait_ack(1'b1, cyc);
    b.d_req = 1'b0;
    chk("lbu_lat", cyc, 3);
    chk("lbu_data", b.d_rdata, 32'h00000080);

    // signed halfword load
    idle_start();
    d_set(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    b.d_req = 1'b1;
    wait_ack(1'b1, cyc);
    b.d_req = 1'b0;
    chk("lh_lat", cyc, 4);
    chk("lh_data", b.d_rdata, 32'hFFFF9001);

    // illegal size, then a legal load
    idle_start();
    d_set(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
    b.d_req = 1'b1;
    wait_ack(1'b1, cyc);
    b.d_req = 1'b0;
    chk("ill_lat", cyc, 1);
    chk("ill_err", b.d_err, 32'h1);
    chk("ill_mem", re_n + we_n, 0);

    idle_start();
    d_set(1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
    b.d_req = 1'b1;
    wait_ack(1'b1, cyc);
    b.d_req = 1'b0;
    chk("post_ill_lat", cyc, 3);
    chk("post_ill_err", b.d_err, 32'h0);
    chk("post_ill_data", b.d_rdata, 32'h80);

    // reset during byte 1 of a word store
    idle_start();
    d_set(1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344);
    b.d_req = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("rs_we", b.mem_we, 32'h1);
    chk("rs_addr", b.mem_addr, 32'h41);
    chk("rs_wdata", b.mem_wdata, 32'h33);
    rst_n = 1'b0;
    #1;
    chk("rs_flags", outs(), 32'h0);
    chk("rs_d_rdata", b.d_rdata, 32'h0);
    chk("rs_if_rdata", b.if_rdata, 32'h0);
    b.d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dc = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (b.d_ack) dc++;
    end
    chk("rs_no_ack", dc, 0);
    chk("rs_we_n", we_n, 1);
    chk("rs_we_a0", we_a[0], 32'h40);
    ea[0] = mem[8'h40];
    ea[1] = mem[8'h41];
    ea[2] = mem[8'h42];
    ea[3] = mem[8'h43];
    chk("rs_mem", {ea[3], ea[2], ea[1], ea[0]},
        32'h00000044);

    // fetch after reset
    idle_start();
    b.if_addr = 32'h10;
    b.if_req  = 1'b1;
    wait_ack(1'b0, cyc);
    b.if_req = 1'b0;
    chk("fetch2_lat", cyc, 6);
    chk("fetch2_data", b.if_rdata, 32'h12345678);

    chk("no_re_we_overlap", ov_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one byte-wide, synchronous-read main memory between the instruction-fetch path and the load/store path.
- Serialises each 8-, 16- or 32-bit access into single-byte memory transfers, assembled little-endian.
- Handles load sign/zero extension and returns results through per-requester req/ack handshakes.
- Sits between the fetch/controller logic and the memory array, using the controller's memory size encoding.

Parameters:
- ADDR_W, 8, width of the memory byte address; request addresses are truncated to ADDR_W bits.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  32  fetch byte address; bits [ADDR_W-1:0] used
- if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle
- if_rdata  out  32  fetched instruction word
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal
- d_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- d_addr  in  32  data byte address
- d_wdata  in  32  store data; low bytes used
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  32  extended load result; valid while d_ack is high
- d_err  out  1  high together with d_ack when d_size = 11
- mem_addr  out  ADDR_W  byte address to memory
- mem_re  out  1  byte read strobe; mem_rdata is valid on the next cycle
- mem_we  out  1  byte write strobe
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, byte counter = 0, assembly register = 0.
  - All outputs are 0.
  - A transfer in progress is abandoned: no ack, and bytes already written stay written.
- FSM states: IDLE, XFER, DRAIN, ACK.
- IDLE:
  - Samples the requests. Fixed priority: d_req beats if_req.
  - Latches the winner's address, direction, size, unsigned flag and wdata.
  - Sets byte count N: fetch = 4; data = 1 / 2 / 4 for size 00 / 01 / 10.
  - Data with d_size = 11: no memory access, next state ACK with d_err = 1.
  - Otherwise next state XFER with cnt = 0.
- XFER (one cycle per byte):
  - mem_addr = base + cnt, modulo 2^ADDR_W (wraps 0xFF -> 0x00 when ADDR_W = 8).
  - Store: mem_we = 1, mem_wdata = wdata byte cnt (bits [8cnt+7:8cnt]).
  - Load/fetch: mem_re = 1. The byte returned in the following cycle is written into assembly byte cnt-1 (pipelined capture).
  - When cnt = N-1: stores go to ACK; loads and fetches go to DRAIN.
- DRAIN: captures the final byte; no strobes asserted; next state ACK.
- ACK:
  - Pulses the owner's ack for exactly one cycle; next state IDLE.
  - d_rdata: byte loads extend from bit 7, halfword loads from bit 15; d_unsigned selects zero or sign extension.
  - if_rdata is the raw 32-bit word.
  - d_rdata and if_rdata hold their values until the next ack of the same port.
- Latency, counted from the cycle a request is seen in IDLE (cycle 0) to ack:
  - Reads: N + 2 (fetch / lw = 6, lb = 3).
  - Writes: N + 1 (sw = 5, sb = 2).
  - Illegal size: 1.
- Back-to-back: a request still high in the IDLE cycle after ACK is re-arbitrated as a new request. Requesters drop req in the cycle after ack to avoid a repeat access.
- Simultaneous requests: data is served first; fetch waits in IDLE with no timeout.
- mem_re and mem_we are never high together. No strobe is asserted in IDLE, DRAIN or ACK.
- Misaligned addresses are legal and handled byte-wise.
- Request inputs that change after being latched are ignored until the next IDLE.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: a one-bit last_grant register (reset = fetch) drives round-robin arbitration. When both requests are pending in IDLE, the requester not granted last wins. A single pending request is always granted.
- Not defined: fixed data-over-fetch priority and no last_grant register.

Test Plan:
- Memory bytes 0x10..0x13 = 0x78,0x56,0x34,0x12; if_req with if_addr = 0x10 -> if_ack exactly 6 cycles later, if_rdata = 0x12345678, four mem_re pulses at addresses 0x10..0x13.
- d_req store, d_size = 01, d_addr = 0xFF, d_wdata = 0xAABBCCDD -> mem_we at 0xFF (byte 0xDD) then 0x00 (byte 0xCC); d_ack 3 cycles after the request is seen; no other writes.
- Load byte 0x80 at 0x20: d_unsigned = 0 -> d_rdata = 0xFFFFFF80; d_unsigned = 1 -> d_rdata = 0x00000080; each with d_ack 3 cycles after the request.
- if_req and d_req raised in the same cycle -> data acks first, fetch starts in the IDLE cycle after d_ack. With ARB_RR_EN and last grant = data, fetch is acked first.
- d_size = 11 -> d_ack and d_err high 1 cycle after the request, no mem_re or mem_we; the following legal request completes with d_err = 0.
- rst_n pulled low during the second byte of a 32-bit store -> all outputs 0 immediately, only byte 0 written, no ack. After release, a new fetch completes normally.
